width_packer: RTL and testbench

//   Packs a stream of narrow IN_W-bit beats into OUT_W-bit words, with a valid/ready handshake on each side.

---
 rtl/width_packer_pkg.sv | 30 +++
 rtl/width_packer_if.sv | 33 +++
 rtl/width_packer_oreg.sv | 62 ++++++
 rtl/width_packer.sv | 103 ++++++++++
 tb/tb_width_packer.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/width_packer_pkg.sv
// rtl/width_packer_pkg.sv - shared helpers for the width packer
// Purpose: lane counter sizing, lane bit-offset mapping and parameter
//          legality check used by width_packer and width_packer_if.
// Ports:   none (package).
package width_packer_pkg;

  // Counter width for RATIO lanes; never below one bit.
  function automatic int lane_cnt_w(input int ratio);
    int w;
    w = $clog2(ratio);
    return (w < 1) ? 1 : w;
  endfunction

  // Bit offset of the LSB of a lane inside the output word.
  function automatic int lane_lsb(input int lane, input int in_w, input int out_w,
                                  input bit msb_first);
    return msb_first ? (out_w - (lane + 1) * in_w) : (lane * in_w);
  endfunction

  function automatic bit params_legal(input int in_w, input int out_w);
    return (in_w > 0) && (in_w <= out_w) && ((out_w % in_w) == 0);
  endfunction

  // Lane count, clamped to 1 so that port widths stay legal even when
  // the parameters are illegal and elaboration is about to fail anyway.
  function automatic int safe_ratio(input int in_w, input int out_w);
    return ((in_w > 0) && (out_w >= in_w)) ? (out_w / in_w) : 1;
  endfunction

endpackage

// File: rtl/width_packer_if.sv
// rtl/width_packer_if.sv - narrow-in / wide-out stream interface
// Purpose: groups the input beat and output word handshakes.
// Signals: in_valid/in_ready/in_data/in_last (beat side),
//          out_valid/out_ready/out_data/out_keep/out_last (word side).
// Modports: slave = packer view, master = producer/consumer view.
interface width_packer_if
  import width_packer_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
) ();
  localparam int RATIO = safe_ratio(IN_W, OUT_W);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [RATIO-1:0] out_keep;
  logic             out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/width_packer_oreg.sv
// rtl/width_packer_oreg.sv - output word register with hold-on-stall
// Purpose: holds the completed word until the consumer takes it.
// Ports: clk, rst_n (async active-low); load_i loads data_i/keep_i/last_i;
//        out_ready_i consumer ready; out_valid_o/out_data_o/out_keep_o/
//        out_last_o registered word.
module width_packer_oreg #(
  parameter int OUT_W  = 32,
  parameter int KEEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [OUT_W-1:0]  data_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic              last_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [OUT_W-1:0]  out_data_o,
  output logic [KEEP_W-1:0] out_keep_o,
  output logic              out_last_o
);
  logic              valid_q, valid_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic              last_q, last_d;

  // load_i only fires when the upstream beat was accepted, which already
  // implies the register is empty or being drained this cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      keep_d  = keep_i;
      last_d  = last_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_keep_o  = keep_q;
  assign out_last_o  = last_q;
endmodule

// File: rtl/width_packer.sv
// rtl/width_packer.sv - packs IN_W-bit beats into OUT_W-bit words
// Purpose: lane counter + accumulator feeding a shared output register;
//          IN_W == OUT_W elaborates a one-register passthrough instead.
// Ports: clk, rst_n (async active-low), bus (width_packer_if.slave).
// Config: WIDTH_PACKER_MSB_FIRST_EN places lane 0 in the MSBs.
module width_packer
  import width_packer_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  width_packer_if.slave  bus
);
  localparam int RATIO = safe_ratio(IN_W, OUT_W);

  if (!params_legal(IN_W, OUT_W)) begin : g_illegal
    $error("width_packer: IN_W must divide OUT_W and be <= OUT_W");
  end

  logic             accept;
  logic             load;
  logic [OUT_W-1:0] word;
  logic [RATIO-1:0] keep;
  logic             last;

  // in_ready depends only on the output register, never on in_valid.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  if (RATIO == 1) begin : g_pass
    assign load = accept;
    assign word = OUT_W'(bus.in_data);
    assign keep = '1;
    assign last = bus.in_last;
  end else begin : g_pack
`ifdef WIDTH_PACKER_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif
    localparam int CNT_W = lane_cnt_w(RATIO);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] merged;
    logic [RATIO-1:0] keep_c;
    logic             complete;

    always_comb begin
      // Accumulator lanes are zero until written, so OR-ing the beat in
      // yields the padded word directly.
      merged   = acc_q | (OUT_W'(bus.in_data) << lane_lsb(int'(cnt_q), IN_W, OUT_W, MSB_FIRST));
      complete = accept && ((cnt_q == CNT_W'(RATIO - 1)) || bus.in_last);
      keep_c   = '0;
      for (int i = 0; i < RATIO; i++) begin
        keep_c[i] = (i <= int'(cnt_q));
      end
      cnt_d = cnt_q;
      acc_d = acc_q;
      if (complete) begin
        cnt_d = '0;
        acc_d = '0;
      end else if (accept) begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = merged;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        acc_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        acc_q <= acc_d;
      end
    end

    assign load = complete;
    assign word = merged;
    assign keep = keep_c;
    assign last = bus.in_last;
  end

  width_packer_oreg #(
    .OUT_W  (OUT_W),
    .KEEP_W (RATIO)
  ) u_oreg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .data_i      (word),
    .keep_i      (keep),
    .last_i      (last),
    .out_ready_i (bus.out_ready),
    .out_valid_o (bus.out_valid),
    .out_data_o  (bus.out_data),
    .out_keep_o  (bus.out_keep),
    .out_last_o  (bus.out_last)
  );
endmodule

// File: tb/tb_width_packer.sv
// tb/tb_width_packer.sv - scoreboard bench for width_packer (8->32 and 32->32)
module tb_width_packer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  width_packer_if #(.IN_W(8),  .OUT_W(32)) bus ();
  width_packer_if #(.IN_W(32), .OUT_W(32)) p_bus ();

  width_packer #(.IN_W(8), .OUT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  width_packer #(.IN_W(32), .OUT_W(32)) dut_pass (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (p_bus)
  );

`ifdef WIDTH_PACKER_MSB_FIRST_EN
  localparam logic [31:0] EXP_T1    = 32'h11223344;
  localparam logic [31:0] EXP_T3    = 32'hAABB0000;
  localparam logic [31:0] EXP_LANE0 = 32'h5A000000;
  localparam logic [31:0] EXP_T5    = 32'h01020304;
`else
  localparam logic [31:0] EXP_T1    = 32'h44332211;
  localparam logic [31:0] EXP_T3    = 32'h0000BBAA;
  localparam logic [31:0] EXP_LANE0 = 32'h0000005A;
  localparam logic [31:0] EXP_T5    = 32'h04030201;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       r;
  } beat_t;

  word_t       sb_q[$];
  int          m_cnt;
  logic [31:0] m_acc;
  int          n_checks;
  int          n_errors;

  // Reference packer: lane placement and keep mask from first principles.
  function automatic void model_accept(input logic [7:0] d, input logic l);
    int lsb;
`ifdef WIDTH_PACKER_MSB_FIRST_EN
    lsb = 24 - 8 * m_cnt;
`else
    lsb = 8 * m_cnt;
`endif
    m_acc = m_acc | (32'(d) << lsb);
    if (m_cnt == 3 || l) begin
      sb_q.push_back('{data: m_acc, keep: 4'((1 << (m_cnt + 1)) - 1), last: l});
      m_cnt = 0;
      m_acc = '0;
    end else begin
      m_cnt++;
    end
  endfunction

  // Drives one cycle of stimulus, updates the model on acceptance, and
  // returns 1 time unit after the clock edge.
  task automatic drive_cycle(input beat_t b);
    bus.in_valid  = b.v;
    bus.in_data   = b.d;
    bus.in_last   = b.l;
    bus.out_ready = b.r;
    if (b.v && (!bus.out_valid || b.r)) model_accept(b.d, b.l);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b, required 0", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h, required 0", bus.out_data); end
    n_checks++;
    if (bus.out_keep !== 4'h0) begin n_errors++; $display("FAIL reset_keep: got %h, required 0", bus.out_keep); end
    n_checks++;
    if (bus.out_last !== 1'b0) begin n_errors++; $display("FAIL reset_last: got %b, required 0", bus.out_last); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
    n_checks++;
    if (p_bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_pass_valid: got %b, required 0", p_bus.out_valid); end
  endtask

  task automatic test_full_word;
    beat_t st[$];
    word_t e;
    st = '{'{1, 8'h11, 0, 1}, '{1, 8'h22, 0, 1}, '{1, 8'h33, 0, 1}, '{1, 8'h44, 0, 1},
           '{0, 8'h00, 0, 1}, '{0, 8'h00, 0, 1}};
    foreach (st[i]) begin
      if (bus.out_valid && st[i].r) begin
        n_checks++;
        if (sb_q.size() == 0) begin n_errors++; $display("FAIL full_unexpected: got %h, required no word", bus.out_data); end
        else begin
          e = sb_q.pop_front();
          if ({bus.out_data, bus.out_keep, bus.out_last} !== e) begin
            n_errors++; $display("FAIL full_word: got %h/%h/%b, required %h/%h/%b",
                                 bus.out_data, bus.out_keep, bus.out_last, e.data, e.keep, e.last);
          end
        end
      end
      drive_cycle(st[i]);
      if (i == 2) begin
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL full_early: got valid %b, required 0", bus.out_valid); end
      end
      if (i == 3) begin
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.out_keep, bus.out_last} !== {1'b1, EXP_T1, 4'hF, 1'b0}) begin
          n_errors++; $display("FAIL full_latency: got %b/%h/%h/%b, required 1/%h/f/0",
                               bus.out_valid, bus.out_data, bus.out_keep, bus.out_last, EXP_T1);
        end
      end
    end
  endtask

  task automatic test_last_flush;
    beat_t st[$];
    word_t e;
    st = '{'{1, 8'hAA, 0, 1}, '{1, 8'hBB, 1, 1}, '{1, 8'h5A, 1, 1},
           '{1, 8'h11, 0, 1}, '{1, 8'h22, 0, 1}, '{1, 8'h33, 0, 1}, '{1, 8'h44, 0, 1},
           '{0, 8'h00, 0, 1}, '{0, 8'h00, 0, 1}};
    foreach (st[i]) begin
      if (bus.out_valid && st[i].r) begin
        n_checks++;
        if (sb_q.size() == 0) begin n_errors++; $display("FAIL flush_unexpected: got %h, required no word", bus.out_data); end
        else begin
          e = sb_q.pop_front();
          if ({bus.out_data, bus.out_keep, bus.out_last} !== e) begin
            n_errors++; $display("FAIL flush_word: got %h/%h/%b, required %h/%h/%b",
                                 bus.out_data, bus.out_keep, bus.out_last, e.data, e.keep, e.last);
          end
        end
      end
      drive_cycle(st[i]);
      if (i == 1) begin
        n_checks++;
        if ({bus.out_data, bus.out_keep, bus.out_last} !== {EXP_T3, 4'h3, 1'b1}) begin
          n_errors++; $display("FAIL flush_partial: got %h/%h/%b, required %h/3/1",
                               bus.out_data, bus.out_keep, bus.out_last, EXP_T3);
        end
      end
      if (i == 2) begin
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.out_keep, bus.out_last} !== {1'b1, EXP_LANE0, 4'h1, 1'b1}) begin
          n_errors++; $display("FAIL flush_lane0: got %b/%h/%h/%b, required 1/%h/1/1",
                               bus.out_valid, bus.out_data, bus.out_keep, bus.out_last, EXP_LANE0);
        end
      end
    end
  endtask

  task automatic test_stall;
    beat_t st[$];
    word_t e;
    st = '{'{1, 8'h11, 0, 0}, '{1, 8'h22, 0, 0}, '{1, 8'h33, 0, 0}, '{1, 8'h44, 0, 0},
           '{1, 8'h55, 0, 0}, '{1, 8'h55, 0, 0}, '{1, 8'h55, 0, 0},
           '{0, 8'h00, 0, 1}, '{0, 8'h00, 0, 1}};
    foreach (st[i]) begin
      if (bus.out_valid && st[i].r) begin
        n_checks++;
        if (sb_q.size() == 0) begin n_errors++; $display("FAIL stall_unexpected: got %h, required no word", bus.out_data); end
        else begin
          e = sb_q.pop_front();
          if ({bus.out_data, bus.out_keep, bus.out_last} !== e) begin
            n_errors++; $display("FAIL stall_word: got %h/%h/%b, required %h/%h/%b",
                                 bus.out_data, bus.out_keep, bus.out_last, e.data, e.keep, e.last);
          end
        end
      end
      drive_cycle(st[i]);
      if (i >= 4 && i <= 6) begin
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_in_ready: got %b, required 0", bus.in_ready); end
        n_checks++;
        if (sb_q.size() == 0) begin n_errors++; $display("FAIL stall_hold: got %h, required a pending word", bus.out_data); end
        else if ({bus.out_valid, bus.out_data, bus.out_keep, bus.out_last} !== {1'b1, sb_q[0]}) begin
          n_errors++; $display("FAIL stall_hold: got %b/%h/%h/%b, required 1/%h/%h/%b",
                               bus.out_valid, bus.out_data, bus.out_keep, bus.out_last,
                               sb_q[0].data, sb_q[0].keep, sb_q[0].last);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    beat_t st[$];
    word_t e;
    for (int k = 1; k <= 8; k++) st.push_back('{1, 8'(k), 0, 1});
    for (int k = 0; k < 4; k++) st.push_back('{1, 8'(8'hF1 + k), 1, 1});
    st.push_back('{0, 8'h00, 0, 1});
    st.push_back('{0, 8'h00, 0, 1});
    foreach (st[i]) begin
      if (bus.out_valid && st[i].r) begin
        n_checks++;
        if (sb_q.size() == 0) begin n_errors++; $display("FAIL b2b_unexpected: got %h, required no word", bus.out_data); end
        else begin
          e = sb_q.pop_front();
          if ({bus.out_data, bus.out_keep, bus.out_last} !== e) begin
            n_errors++; $display("FAIL b2b_word: got %h/%h/%b, required %h/%h/%b",
                                 bus.out_data, bus.out_keep, bus.out_last, e.data, e.keep, e.last);
          end
        end
      end
      if (st[i].v) begin
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_bubble: beat %0d in_ready %b, required 1", i, bus.in_ready); end
      end
      drive_cycle(st[i]);
    end
  endtask

  task automatic test_reset_mid;
    beat_t st[$];
    word_t e;
    drive_cycle('{1, 8'h01, 0, 1});
    drive_cycle('{1, 8'h02, 0, 1});
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    m_cnt = 0;
    m_acc = '0;
    sb_q.delete();
    n_checks++;
    if ({bus.out_valid, bus.out_data, bus.out_keep, bus.out_last} !== 38'h0) begin
      n_errors++; $display("FAIL midreset_outputs: got %b/%h/%h/%b, required all 0",
                           bus.out_valid, bus.out_data, bus.out_keep, bus.out_last);
    end
    rst_n = 1'b1;
    st = '{'{1, 8'h01, 0, 1}, '{1, 8'h02, 0, 1}, '{1, 8'h03, 0, 1}, '{1, 8'h04, 0, 1},
           '{0, 8'h00, 0, 1}, '{0, 8'h00, 0, 1}};
    foreach (st[i]) begin
      if (bus.out_valid && st[i].r) begin
        n_checks++;
        if (sb_q.size() == 0) begin n_errors++; $display("FAIL midreset_unexpected: got %h, required no word", bus.out_data); end
        else begin
          e = sb_q.pop_front();
          if ({bus.out_data, bus.out_keep, bus.out_last} !== e) begin
            n_errors++; $display("FAIL midreset_word: got %h/%h/%b, required %h/%h/%b",
                                 bus.out_data, bus.out_keep, bus.out_last, e.data, e.keep, e.last);
          end
        end
      end
      drive_cycle(st[i]);
      if (i == 3) begin
        n_checks++;
        if ({bus.out_data, bus.out_keep} !== {EXP_T5, 4'hF}) begin
          n_errors++; $display("FAIL midreset_first: got %h/%h, required %h/f", bus.out_data, bus.out_keep, EXP_T5);
        end
      end
    end
  endtask

  task automatic test_passthrough;
    p_bus.in_valid = 1'b1; p_bus.in_data = 32'hDEADBEEF; p_bus.in_last = 1'b1; p_bus.out_ready = 1'b1;
    @(posedge clk); #1;
    p_bus.in_valid = 1'b0;
    n_checks++;
    if ({p_bus.out_valid, p_bus.out_data, p_bus.out_keep, p_bus.out_last} !== {1'b1, 32'hDEADBEEF, 1'b1, 1'b1}) begin
      n_errors++; $display("FAIL pass_last: got %b/%h/%b/%b, required 1/deadbeef/1/1",
                           p_bus.out_valid, p_bus.out_data, p_bus.out_keep, p_bus.out_last);
    end
    p_bus.in_valid = 1'b1; p_bus.in_data = 32'h12345678; p_bus.in_last = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({p_bus.out_valid, p_bus.out_data, p_bus.out_last} !== {1'b1, 32'h12345678, 1'b0}) begin
      n_errors++; $display("FAIL pass_b2b: got %b/%h/%b, required 1/12345678/0",
                           p_bus.out_valid, p_bus.out_data, p_bus.out_last);
    end
    p_bus.out_ready = 1'b0; p_bus.in_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    n_checks++;
    if ({p_bus.in_ready, p_bus.out_valid, p_bus.out_data} !== {1'b0, 1'b1, 32'h12345678}) begin
      n_errors++; $display("FAIL pass_stall: got rdy %b valid %b data %h, required 0/1/12345678",
                           p_bus.in_ready, p_bus.out_valid, p_bus.out_data);
    end
    p_bus.in_valid = 1'b0; p_bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (p_bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL pass_drain: got valid %b, required 0", p_bus.out_valid); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_cnt    = 0;
    m_acc    = '0;
    rst_n    = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    p_bus.in_valid = 1'b0; p_bus.in_data = '0; p_bus.in_last = 1'b0; p_bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_full_word();
    test_last_flush();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_passthrough();
    n_checks++;
    if (sb_q.size() != 0) begin n_errors++; $display("FAIL words_left: got %0d pending, required 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
